// File: rtl/cpu_pkg.sv
// Shared types for the CPU sequencer: opcodes, state indices, run modes.
package cpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_AND = 2'b01,
        OP_JMP = 2'b10,
        OP_INC = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        STEP   = 2'd2
    } mode_e;

    localparam int unsigned FETCH1_IDX = 0;
    localparam int unsigned FETCH2_IDX = 1;
    localparam int unsigned FETCH3_IDX = 2;
    localparam int unsigned ADD1_IDX   = 3;
    localparam int unsigned ADD2_IDX   = 4;
    localparam int unsigned AND1_IDX   = 5;
    localparam int unsigned AND2_IDX   = 6;
    localparam int unsigned JMP1_IDX   = 7;
    localparam int unsigned INC1_IDX   = 8;

    function automatic logic [3:0] entry_idx(input opcode_e op);
        case (op)
            OP_ADD:  entry_idx = 4'(ADD1_IDX);
            OP_AND:  entry_idx = 4'(AND1_IDX);
            OP_JMP:  entry_idx = 4'(JMP1_IDX);
            default: entry_idx = 4'(INC1_IDX);
        endcase
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Count to one-hot decoder with enable; purely combinational, no flow control.
module onehot_decode #(
    parameter int N     = 9,
    parameter int CNT_W = 4
) (
    input  logic [CNT_W-1:0] idx_i,
    input  logic             en_i,
    output logic [N-1:0]     onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < N; i++) begin
            onehot_o[i] = en_i && (idx_i == CNT_W'(i));
        end
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Sequence counter and one-hot state generator with run/halt/step control.
// One cycle from command to CPU_state; halts only at instruction boundaries.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int states = 9,
    parameter int CNT_W  = 4,
    parameter int ICNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              COUNTER_LD,
    input  logic              COUNTER_INC,
    input  logic              COUNTER_CLR,
    input  logic [1:0]        opcode,
    input  logic              halt_req,
    input  logic              step,
    output logic [states-1:0] CPU_state,
    output logic              halted,
    output logic              instr_retired,
    output logic [ICNT_W-1:0] instr_count,
    output logic              seq_err
);

    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [states-1:0]  state_q, state_d;
    logic               retired_q, clr_commit;
    logic [ICNT_W-1:0]  icnt_q;
    logic               err_q, err_d;
    logic               multi_cmd;

    assign multi_cmd = (COUNTER_LD & COUNTER_INC) | (COUNTER_LD & COUNTER_CLR)
                     | (COUNTER_INC & COUNTER_CLR);

    always_comb begin
        mode_d     = mode_q;
        count_d    = count_q;
        err_d      = err_q;
        clr_commit = 1'b0;
        if (mode_q == HALTED) begin
            if (!halt_req) begin
                mode_d = RUN;
            end else if (step) begin
                mode_d = STEP;
            end
        end else if (mode_q == RUN && count_q == CNT_W'(FETCH1_IDX) && halt_req) begin
            // FETCH1 only copies PC->AR, so dropping its commands is harmless.
            mode_d = HALTED;
        end else if (multi_cmd) begin
            count_d = '0;
            err_d   = 1'b1;
        end else if (COUNTER_CLR) begin
            count_d    = '0;
            clr_commit = 1'b1;
            if (mode_q == STEP) begin
                mode_d = HALTED;
            end
        end else if (COUNTER_LD) begin
            count_d = CNT_W'(entry_idx(opcode_e'(opcode)));
            if (count_q != CNT_W'(FETCH3_IDX)) begin
                err_d = 1'b1;
            end
        end else if (COUNTER_INC) begin
            if (count_q == CNT_W'(INC1_IDX)) begin
                count_d = '0;
                err_d   = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    onehot_decode #(
        .N     (states),
        .CNT_W (CNT_W)
    ) u_decode (
        .idx_i    (count_d),
        .en_i     (mode_d != HALTED),
        .onehot_o (state_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= RUN;
            count_q   <= '0;
            state_q   <= states'(1);
            retired_q <= 1'b0;
            icnt_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            count_q   <= count_d;
            state_q   <= state_d;
            retired_q <= clr_commit;
            icnt_q    <= icnt_q + ICNT_W'(clr_commit);
            err_q     <= err_d;
        end
    end

    assign CPU_state     = state_q;
    assign halted        = (mode_q == HALTED);
    assign instr_retired = retired_q;
    assign instr_count   = icnt_q;
    assign seq_err       = err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer.
module tb_cpu_sequencer;

    logic        clk;
    logic        rst;
    logic        COUNTER_LD, COUNTER_INC, COUNTER_CLR;
    logic [1:0]  opcode;
    logic        halt_req, step;
    logic [8:0]  CPU_state;
    logic        halted, instr_retired, seq_err;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    cpu_sequencer #(.states(9), .CNT_W(4), .ICNT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .COUNTER_LD    (COUNTER_LD),
        .COUNTER_INC   (COUNTER_INC),
        .COUNTER_CLR   (COUNTER_CLR),
        .opcode        (opcode),
        .halt_req      (halt_req),
        .step          (step),
        .CPU_state     (CPU_state),
        .halted        (halted),
        .instr_retired (instr_retired),
        .instr_count   (instr_count),
        .seq_err       (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one command for one edge, then return the command lines to idle.
    task automatic cmd(input logic ld, input logic inc, input logic clr, input logic [1:0] op);
        COUNTER_LD  = ld;
        COUNTER_INC = inc;
        COUNTER_CLR = clr;
        opcode      = op;
        tick();
        COUNTER_LD  = 1'b0;
        COUNTER_INC = 1'b0;
        COUNTER_CLR = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        COUNTER_LD = 1'b0; COUNTER_INC = 1'b0; COUNTER_CLR = 1'b0;
        opcode = 2'b00; halt_req = 1'b0; step = 1'b0;
        #2;
        check("rst_state",   CPU_state, 9'h001);
        check("rst_halted",  halted, 1'b0);
        check("rst_retired", instr_retired, 1'b0);
        check("rst_icnt",    instr_count, 16'd0);
        check("rst_err",     seq_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ADD instruction
        cmd(0, 1, 0, 2'b00); check("add_f2", CPU_state, 9'h002);
        cmd(0, 1, 0, 2'b00); check("add_f3", CPU_state, 9'h004);
        check("add_noret", instr_retired, 1'b0);
        cmd(1, 0, 0, 2'b00); check("add_a1", CPU_state, 9'h008);
        cmd(0, 1, 0, 2'b00); check("add_a2", CPU_state, 9'h010);
        cmd(0, 0, 1, 2'b00); check("add_f1", CPU_state, 9'h001);
        check("add_ret", instr_retired, 1'b1);
        check("add_icnt", instr_count, 16'd1);
        tick();
        check("add_ret_end", instr_retired, 1'b0);
        check("add_hold", CPU_state, 9'h001);
        check("add_err", seq_err, 1'b0);

        // INC instruction
        cmd(0, 1, 0, 2'b00); cmd(0, 1, 0, 2'b00);
        cmd(1, 0, 0, 2'b11); check("inc_i1", CPU_state, 9'h100);
        cmd(0, 0, 1, 2'b00); check("inc_f1", CPU_state, 9'h001);
        check("inc_icnt", instr_count, 16'd2);
        check("inc_err", seq_err, 1'b0);

        // AND with halt request raised during AND2
        cmd(0, 1, 0, 2'b00); cmd(0, 1, 0, 2'b00);
        cmd(1, 0, 0, 2'b01); check("and_a1", CPU_state, 9'h020);
        cmd(0, 1, 0, 2'b00); check("and_a2", CPU_state, 9'h040);
        halt_req = 1'b1;
        cmd(0, 0, 1, 2'b00); check("halt_f1", CPU_state, 9'h001);
        check("halt_f1_h", halted, 1'b0);
        check("halt_icnt", instr_count, 16'd3);
        cmd(0, 1, 0, 2'b00); check("halt_state", CPU_state, 9'h000);
        check("halt_h", halted, 1'b1);
        cmd(0, 1, 0, 2'b00); check("halt_ign", CPU_state, 9'h000);
        halt_req = 1'b0;
        tick();
        check("resume_f1", CPU_state, 9'h001);
        check("resume_h", halted, 1'b0);

        // Single-step one JMP
        halt_req = 1'b1;
        tick(); check("step_halt", halted, 1'b1);
        step = 1'b1; tick(); step = 1'b0;
        check("step_f1", CPU_state, 9'h001);
        check("step_h", halted, 1'b0);
        cmd(0, 1, 0, 2'b00); check("step_f2", CPU_state, 9'h002);
        cmd(0, 1, 0, 2'b00); check("step_f3", CPU_state, 9'h004);
        cmd(1, 0, 0, 2'b10); check("step_j1", CPU_state, 9'h080);
        cmd(0, 0, 1, 2'b00); check("step_end", CPU_state, 9'h000);
        check("step_end_h", halted, 1'b1);
        check("step_ret", instr_retired, 1'b1);
        check("step_icnt", instr_count, 16'd4);
        tick(); check("step_stay", CPU_state, 9'h000);
        halt_req = 1'b0;
        tick(); check("step_resume", CPU_state, 9'h001);

        // INC and CLR together at count 3
        cmd(0, 1, 0, 2'b00); cmd(0, 1, 0, 2'b00);
        cmd(1, 0, 0, 2'b00); check("multi_pre", CPU_state, 9'h008);
        cmd(0, 1, 1, 2'b00); check("multi_state", CPU_state, 9'h001);
        check("multi_err", seq_err, 1'b1);
        check("multi_noret", instr_retired, 1'b0);
        check("multi_icnt", instr_count, 16'd4);

        // Asynchronous reset at count 4
        cmd(0, 1, 0, 2'b00); cmd(0, 1, 0, 2'b00);
        cmd(1, 0, 0, 2'b00); cmd(0, 1, 0, 2'b00);
        check("pre_rst", CPU_state, 9'h010);
        #2 rst = 1'b1;
        #1;
        check("arst_state", CPU_state, 9'h001);
        check("arst_icnt", instr_count, 16'd0);
        check("arst_err", seq_err, 1'b0);
        tick();
        rst = 1'b0;

        // INC at count 8 wraps and flags an error
        cmd(0, 1, 0, 2'b00); cmd(0, 1, 0, 2'b00);
        cmd(1, 0, 0, 2'b11); check("wrap_pre", CPU_state, 9'h100);
        check("wrap_pre_err", seq_err, 1'b0);
        cmd(0, 1, 0, 2'b00); check("wrap_state", CPU_state, 9'h001);
        check("wrap_err", seq_err, 1'b1);
        check("wrap_noret", instr_retired, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
